mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified Memory between instruction fetch (IF) and the MEM-stage data port (D).

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// Owner encoding tracks which port the in-flight read belongs to.
package mem_port_arbiter_pkg;

   localparam int OWN_W = 2;

   typedef enum logic [OWN_W-1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } own_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the port arbiter.
// The arbiter takes the slave view; the pipeline/memory model the master view.
interface mem_port_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_stall;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_stall;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic        mem_rd_en;
   logic [31:0] mem_rd;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      output if_gnt, if_stall, if_rvalid, if_rdata,
      output d_gnt, d_stall, d_rvalid, d_rdata, d_err,
      output mem_a, mem_wd, mem_we, mem_rd_en
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      input  if_gnt, if_stall, if_rvalid, if_rdata,
      input  d_gnt, d_stall, d_rvalid, d_rdata, d_err,
      input  mem_a, mem_wd, mem_we, mem_rd_en
   );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive denied IF cycles; asserts force_gnt at the limit.
// Saturates so a long D burst cannot wrap the count.
module arb_starve_counter #(
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic CLK,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic force_gnt
);

   localparam logic [3:0] MAX = 4'(MAX_WAIT);

   logic [3:0] cnt;

   always_ff @(posedge CLK) begin
      if (reset)
         cnt <= 4'd0;
      else if (gnt || !req)
         cnt <= 4'd0;
      else if (cnt != MAX)
         cnt <= cnt + 4'd1;
   end

   assign force_gnt = (cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares single-ported unified memory between IF and the MEM-stage D port.
// D wins by default; a starved IF is forced through after IF_MAX_WAIT denials.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned IF_MAX_WAIT = 3,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic               CLK,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   own_t own_q;
   own_t own_d;
   logic force_if;
   logic mis;
   logic d_rd_issue;

   arb_starve_counter #(
      .MAX_WAIT (IF_MAX_WAIT)
   ) u_starve (
      .CLK       (CLK),
      .reset     (reset),
      .req       (bus.if_req),
      .gnt       (bus.if_gnt),
      .force_gnt (force_if)
   );

   assign mis = CHECK_ALIGN && misaligned(bus.d_addr);

   always_comb begin
      bus.if_gnt = 1'b0;
      bus.d_gnt  = 1'b0;
      if (!reset) begin
         if (bus.d_req && !force_if)
            bus.d_gnt = 1'b1;
         else if (bus.if_req)
            bus.if_gnt = 1'b1;
         else if (bus.d_req)
            bus.d_gnt = 1'b1;
      end
   end

   assign bus.if_stall = bus.if_req & ~bus.if_gnt;
   assign bus.d_stall  = bus.d_req & ~bus.d_gnt;
   assign d_rd_issue   = bus.d_gnt & ~bus.d_we & ~mis;

   // Misaligned D accesses are granted but never reach memory.
   always_comb begin
      bus.mem_a     = 32'd0;
      bus.mem_we    = 1'b0;
      bus.mem_rd_en = 1'b0;
      if (bus.if_gnt) begin
         bus.mem_a     = bus.if_addr;
         bus.mem_rd_en = 1'b1;
      end else if (bus.d_gnt) begin
         bus.mem_a     = bus.d_addr;
         bus.mem_we    = bus.d_we & ~mis;
         bus.mem_rd_en = d_rd_issue;
      end
   end

   assign bus.mem_wd = bus.d_wdata;

   always_ff @(posedge CLK) begin
      if (reset)
         own_q <= OWN_NONE;
      else
         own_q <= own_d;
   end

   // Reset also squashes the return landing in the reset cycle.
   always_comb begin
      own_d         = OWN_NONE;
      bus.if_rvalid = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.if_rdata  = 32'd0;
      bus.d_rdata   = 32'd0;
      if (bus.if_gnt)
         own_d = OWN_IF;
      else if (d_rd_issue)
         own_d = OWN_D;
      if (!reset) begin
         unique case (own_q)
            OWN_IF: begin
               bus.if_rvalid = 1'b1;
               bus.if_rdata  = bus.mem_rd;
            end
            OWN_D: begin
               bus.d_rvalid = 1'b1;
               bus.d_rdata  = bus.mem_rd;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset)
         bus.d_err <= 1'b0;
      else
         bus.d_err <= bus.d_gnt & mis;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int MAXW = 3;

   logic CLK = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] mem [0:1023];

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .IF_MAX_WAIT (MAXW),
      .CHECK_ALIGN (1'b1)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Memory model: registered read, write on posedge.
   always @(posedge CLK) begin
      if (bus.mem_we)
         mem[bus.mem_a[11:2]] <= bus.mem_wd;
      bus.mem_rd <= mem[bus.mem_a[11:2]];
   end

   task automatic go();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.if_req  = 1'b0;
      bus.if_addr = 32'd0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'd0;
      bus.d_wdata = 32'd0;
   endtask

   task automatic test_reset();
      idle();
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b1;
      reset      = 1'b1;
      go();
      go();
      @(negedge CLK);
      checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_we, bus.mem_rd_en} !== 4'b0) begin
         errors++;
         $display("FAIL reset_gnt got %b want 0000",
                  {bus.if_gnt, bus.d_gnt, bus.mem_we, bus.mem_rd_en});
      end
      go();
      reset = 1'b0;
      idle();
      @(negedge CLK);
      checks++;
      if ({bus.if_rvalid, bus.d_rvalid, bus.d_err} !== 3'b0 ||
          bus.if_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_out got %b want 000",
                  {bus.if_rvalid, bus.d_rvalid, bus.d_err});
      end
      go();
   endtask

   task automatic test_if_only();
      for (int k = 0; k < 4; k++) begin
         bus.if_req  = (k < 3);
         bus.if_addr = 32'(k * 4);
         @(negedge CLK);
         if (k < 3) begin
            checks++;
            if (bus.if_gnt !== 1'b1 || bus.mem_a !== 32'(k * 4)) begin
               errors++;
               $display("FAIL if_only_gnt k=%0d got %b/%h want 1/%h",
                        k, bus.if_gnt, bus.mem_a, k * 4);
            end
         end
         if (k > 0) begin
            checks++;
            if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== mem[k-1]) begin
               errors++;
               $display("FAIL if_only_rd k=%0d got %b/%h want 1/%h",
                        k, bus.if_rvalid, bus.if_rdata, mem[k-1]);
            end
         end
         go();
      end
      idle();
   endtask

   task automatic test_conflict();
      logic [31:0] dexp;
      logic [31:0] iexp;
      dexp = mem[257];
      iexp = mem[4];
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h404;
      @(negedge CLK);
      checks++;
      if ({bus.d_gnt, bus.if_gnt, bus.if_stall} !== 3'b101) begin
         errors++;
         $display("FAIL conflict_gnt got %b want 101",
                  {bus.d_gnt, bus.if_gnt, bus.if_stall});
      end
      go();
      bus.d_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== dexp ||
          bus.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL conflict_d got %b/%h/%b want 1/%h/1",
                  bus.d_rvalid, bus.d_rdata, bus.if_gnt, dexp);
      end
      go();
      idle();
      @(negedge CLK);
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== iexp) begin
         errors++;
         $display("FAIL conflict_if got %b/%h want 1/%h",
                  bus.if_rvalid, bus.if_rdata, iexp);
      end
      go();
   endtask

   task automatic test_starve();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h20;
      bus.d_req   = 1'b1;
      bus.d_addr  = 32'h408;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         checks++;
         if (bus.d_stall !== (c == 3) || bus.if_gnt !== (c == 3)) begin
            errors++;
            $display("FAIL starve c=%0d got stall=%b ifg=%b want %b",
                     c, bus.d_stall, bus.if_gnt, c == 3);
         end
         go();
      end
      idle();
      go();
   endtask

   task automatic test_write_read();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h408;
      bus.d_wdata = 32'hDEADBEEF;
      @(negedge CLK);
      checks++;
      if ({bus.d_gnt, bus.mem_we, bus.mem_rd_en} !== 3'b110 ||
          bus.mem_wd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_issue got %b/%h want 110/deadbeef",
                  {bus.d_gnt, bus.mem_we, bus.mem_rd_en}, bus.mem_wd);
      end
      go();
      bus.d_we = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.mem_rd_en !== 1'b1 || bus.d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_issue got rd_en=%b rvalid=%b want 1/0",
                  bus.mem_rd_en, bus.d_rvalid);
      end
      go();
      idle();
      @(negedge CLK);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rd got %b/%h want 1/deadbeef",
                  bus.d_rvalid, bus.d_rdata);
      end
      go();
   endtask

   task automatic test_misalign();
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h405;
      @(negedge CLK);
      checks++;
      if ({bus.d_gnt, bus.mem_rd_en, bus.d_err} !== 3'b100) begin
         errors++;
         $display("FAIL mis_issue got %b want 100",
                  {bus.d_gnt, bus.mem_rd_en, bus.d_err});
      end
      go();
      idle();
      @(negedge CLK);
      checks++;
      if ({bus.d_err, bus.d_rvalid} !== 2'b10) begin
         errors++;
         $display("FAIL mis_err got %b want 10", {bus.d_err, bus.d_rvalid});
      end
      go();
      @(negedge CLK);
      checks++;
      if (bus.d_err !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse got %b want 0", bus.d_err);
      end
      go();
   endtask

   task automatic test_reset_mid();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h30;
      go();
      idle();
      reset = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid got %b/%h want 0/0",
                  bus.if_rvalid, bus.if_rdata);
      end
      go();
      reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_after got %b want 0", bus.if_rvalid);
      end
      go();
      // Build up IF denials, reset, then D must win three straight cycles.
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h40C;
      go();
      go();
      reset = 1'b1;
      go();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         checks++;
         if (bus.d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_starve c=%0d got d_gnt=%b want 1",
                     c, bus.d_gnt);
         end
         go();
      end
      idle();
      go();
   endtask

   task automatic test_random();
      int          wcnt;
      int          pend;
      logic [31:0] pdata;
      logic        perr;
      logic        frc, e_if, e_d, mis, e_we, e_rd, e_ifv, e_dv;
      logic [31:0] e_a, e_ird, e_drd;
      logic [8:0]  got, exp;
      idle();
      reset = 1'b1;
      go();
      reset = 1'b0;
      wcnt  = 0;
      pend  = 0;
      pdata = 32'd0;
      perr  = 1'b0;
      for (int n = 0; n < 400; n++) begin
         reset       = ($urandom_range(0, 49) == 0);
         bus.if_req  = $urandom_range(0, 3) != 0;
         bus.if_addr = {20'd0, 10'($urandom), 2'b00};
         bus.d_req   = $urandom_range(0, 2) != 0;
         bus.d_we    = $urandom_range(0, 2) == 0;
         bus.d_addr  = {20'd0, 12'($urandom)};
         if ($urandom_range(0, 7) != 0)
            bus.d_addr[1:0] = 2'b00;
         bus.d_wdata = $urandom;
         @(negedge CLK);
         frc   = (wcnt == MAXW);
         e_d   = !reset && bus.d_req && !(frc && bus.if_req);
         e_if  = !reset && bus.if_req && !e_d;
         mis   = bus.d_addr[1:0] != 2'b00;
         e_a   = e_if ? bus.if_addr : (e_d ? bus.d_addr : 32'd0);
         e_we  = e_d && bus.d_we && !mis;
         e_rd  = e_if || (e_d && !bus.d_we && !mis);
         e_ifv = !reset && pend == 1;
         e_dv  = !reset && pend == 2;
         e_ird = e_ifv ? pdata : 32'd0;
         e_drd = e_dv ? pdata : 32'd0;
         got = {bus.if_gnt, bus.d_gnt, bus.if_stall, bus.d_stall,
                bus.mem_we, bus.mem_rd_en, bus.if_rvalid, bus.d_rvalid,
                bus.d_err};
         exp = {e_if, e_d, bus.if_req && !e_if, bus.d_req && !e_d,
                e_we, e_rd, e_ifv, e_dv, perr};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rnd_ctl n=%0d got %b want %b", n, got, exp);
         end
         checks++;
         if (bus.mem_a !== e_a || bus.mem_wd !== bus.d_wdata) begin
            errors++;
            $display("FAIL rnd_mem n=%0d got %h want %h", n, bus.mem_a, e_a);
         end
         checks++;
         if (bus.if_rdata !== e_ird || bus.d_rdata !== e_drd) begin
            errors++;
            $display("FAIL rnd_data n=%0d got %h/%h want %h/%h",
                     n, bus.if_rdata, bus.d_rdata, e_ird, e_drd);
         end
         pdata = mem[e_a[11:2]];
         perr  = e_d && mis;
         if (reset)
            pend = 0;
         else if (e_if)
            pend = 1;
         else if (e_d && !bus.d_we && !mis)
            pend = 2;
         else
            pend = 0;
         if (reset || e_if || !bus.if_req)
            wcnt = 0;
         else if (wcnt < MAXW)
            wcnt = wcnt + 1;
         go();
      end
      reset = 1'b0;
      idle();
      go();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] = $urandom;
      idle();
      reset = 1'b1;
      #1;
      test_reset();
      test_if_only();
      test_conflict();
      test_starve();
      test_write_read();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
